// File: rtl/supersweet_pkg.sv
// Shared types and constants for the FIFO-to-SPI drain path.
// No logic; compile-time definitions only.
// Not applicable: no flow control lives here.
package supersweet_pkg;

   // Drain FSM states, in visiting order.
   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      SHIFT,
      HOLD,
      GAP
   } drain_state_e;

   // SPI mode 0: clock idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   // Word width shared with the single-entry data FIFO.
   localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: pulses tick once every CLK_DIV enabled cycles.
// Latency: tick is combinational from the counter; first tick on the CLK_DIV-th enabled cycle after clear.
// No backpressure; the counter simply holds while enable is low.
module spi_half_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LIM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count enabled cycles, wrapping to zero on the tick so periods run back to back.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == LIM) begin
            tick  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fifo_spi_drain.sv
// Pops one word from a single-entry FIFO whenever it is full and shifts it out MSB-first over SPI mode 0.
// Latency: strobe one cycle after fifo_full seen in IDLE; cs_n falls two cycles after the strobe.
// No backpressure into the FIFO: a pop is only issued from IDLE, and fifo_full is ignored while busy.
module fifo_spi_drain
   import supersweet_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CLK_DIV    = 2,
   parameter int CS_GAP     = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_full,
   output logic                  fifo_read_strobe,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  cs_n,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_sent
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int GW = $clog2(CS_GAP + 1);

   drain_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
   logic                  strobe_q, strobe_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  busy_q, busy_d;
   logic [CNT_WIDTH-1:0]  words_q, words_d;

   logic tick_clear;
   logic tick_en;
   logic tick;

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .clk    (clk),
      .rst    (rst),
      .clear  (tick_clear),
      .enable (tick_en),
      .tick   (tick)
   );

   // Next-state and registered-output logic for the drain sequence.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      strobe_d   = 1'b0;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      words_d    = words_q;
      tick_clear = 1'b0;
      tick_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_full) begin
               strobe_d = 1'b1;
               state_d  = POP;
            end
         end
         POP: begin
            // FIFO data is stable this cycle; grab it before the FIFO may take a new write.
            shift_d = fifo_read_data;
            state_d = LOAD;
         end
         LOAD: begin
            cs_n_d     = 1'b0;
            mosi_d     = shift_q[DATA_WIDTH-1];
            sclk_d     = SPI_CPOL;
            bit_cnt_d  = '0;
            tick_clear = 1'b1;
            state_d    = SHIFT;
         end
         SHIFT: begin
            tick_en = 1'b1;
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d    = 1'b1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BW'(DATA_WIDTH)) begin
                     state_d = HOLD;
                  end else begin
                     shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                     mosi_d  = shift_q[DATA_WIDTH-2];
                  end
               end
            end
         end
         HOLD: begin
            // Keep cs_n low for one more half period after the last falling edge.
            tick_en = 1'b1;
            if (tick) begin
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               words_d   = words_q + 1'b1;
               gap_cnt_d = '0;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == GW'(CS_GAP - 1)) state_d = IDLE;
            else                              gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset drops any word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         strobe_q  <= 1'b0;
         sclk_q    <= SPI_CPOL;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         strobe_q  <= strobe_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         words_q   <= words_d;
      end
   end

   assign fifo_read_strobe = strobe_q;
   assign sclk             = sclk_q;
   assign mosi             = mosi_q;
   assign cs_n             = cs_n_q;
   assign busy             = busy_q;
   assign words_sent       = words_q;

endmodule

// File: tb/tb_fifo_spi_drain.sv
// Bench for fifo_spi_drain: single-entry FIFO model, SPI frame monitor and word scoreboard.
// Latency: checks frame timing against the fixed CLK_DIV/CS_GAP schedule.
// FIFO model flags an overrun when written while full without a coincident pop.
module tb_fifo_spi_drain;

   localparam int DW  = 16;
   localparam int CD  = 2;
   localparam int GAP = 4;
   localparam int CW  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_full;
   logic          fifo_read_strobe;
   logic [DW-1:0] fifo_read_data;
   logic          sclk;
   logic          mosi;
   logic          cs_n;
   logic          busy;
   logic [CW-1:0] words_sent;

   // FIFO model state
   logic          fifo_rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          fifo_fault;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] exp_q[$];

   // Monitor state
   logic          sclk_prev = 1'b0;
   logic          cs_prev   = 1'b1;
   int            cyc = 0;
   int            start_cyc = 0;
   int            cs_low_cnt = 0;
   int            rx_bits = 0;
   logic [DW-1:0] rx_word = '0;
   int            last_rise = -1;
   int            spacing_err = 0;
   int            gap_cnt = 0;
   int            frames_seen = 0;
   int            strobe_cnt = 0;
   logic          discard = 1'b0;
   logic [DW-1:0] exp_word;

   always #5 clk = ~clk;

   fifo_spi_drain #(
      .DATA_WIDTH (DW),
      .CLK_DIV    (CD),
      .CS_GAP     (GAP),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fifo_full        (fifo_full),
      .fifo_read_strobe (fifo_read_strobe),
      .fifo_read_data   (fifo_read_data),
      .sclk             (sclk),
      .mosi             (mosi),
      .cs_n             (cs_n),
      .busy             (busy),
      .words_sent       (words_sent)
   );

   // Single-entry FIFO: write wins over a coincident pop; write while full without pop is an overrun.
   always @(posedge clk) begin
      if (fifo_rst) begin
         fifo_full      <= 1'b0;
         fifo_read_data <= '0;
         fifo_fault     <= 1'b0;
      end else if (wr_en) begin
         if (fifo_full && !fifo_read_strobe) fifo_fault <= 1'b1;
         fifo_read_data <= wr_data;
         fifo_full      <= 1'b1;
      end else if (fifo_read_strobe) begin
         fifo_full <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SPI monitor: sample on the falling clk edge, collect bits on sclk rises, score each frame.
   always @(negedge clk) begin
      cyc++;
      if (fifo_read_strobe === 1'b1) strobe_cnt++;
      if (cs_n === 1'b0 && cs_prev === 1'b1) begin
         if (frames_seen > 0) chk("cs_gap_min", 32'(gap_cnt >= GAP), 1);
         cs_low_cnt  = 0;
         rx_bits     = 0;
         rx_word     = '0;
         last_rise   = -1;
         spacing_err = 0;
         start_cyc   = cyc;
      end
      if (cs_n === 1'b0) begin
         cs_low_cnt++;
         if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            rx_word = {rx_word[DW-2:0], mosi};
            rx_bits++;
            if (rx_bits == 1) chk("first_rise_delay", 32'(cyc - start_cyc), CD);
            if (last_rise >= 0 && (cyc - last_rise) != 2 * CD) spacing_err++;
            last_rise = cyc;
         end
      end
      if (cs_n === 1'b1 && cs_prev === 1'b0) begin
         if (discard) begin
            discard = 1'b0;
         end else begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               exp_word = exp_q.pop_front();
               chk("frame_word", 32'(rx_word), 32'(exp_word));
            end
            chk("frame_bits", 32'(rx_bits), DW);
            chk("cs_low_cycles", 32'(cs_low_cnt), DW * 2 * CD + CD);
            chk("sclk_spacing_err", 32'(spacing_err), 0);
            frames_seen++;
         end
         gap_cnt = 0;
      end
      if (cs_n === 1'b1) gap_cnt++;
      sclk_prev = sclk;
      cs_prev   = cs_n;
   end

   // Caller sits at a falling edge; write lasts one clk cycle.
   task automatic fifo_write(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max; i++) begin
         if (!fifo_full && !busy && exp_q.size() == 0) return;
         @(negedge clk);
      end
      chk("drain_timeout", 0, 1);
   endtask

   task automatic wait_full_low(input int max);
      for (int i = 0; i < max; i++) begin
         if (!fifo_full) return;
         @(negedge clk);
      end
      chk("full_low_timeout", 0, 1);
   endtask

   task automatic wait_strobe(input int max);
      for (int i = 0; i < max; i++) begin
         if (fifo_read_strobe) return;
         @(negedge clk);
      end
      chk("strobe_timeout", 0, 1);
   endtask

   task automatic wait_bits(input int n, input int max);
      for (int i = 0; i < max; i++) begin
         if (rx_bits == n) return;
         @(negedge clk);
      end
      chk("bit_wait_timeout", 0, 1);
   endtask

   logic [DW-1:0] dropped;

   initial begin
      rst      = 1'b1;
      fifo_rst = 1'b1;
      wr_en    = 1'b0;
      wr_data  = '0;

      // Reset values
      @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 1);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_mosi", 32'(mosi), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobe", 32'(fifo_read_strobe), 0);
      chk("rst_words", 32'(words_sent), 0);
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      fifo_rst = 1'b0;

      // Idle with an empty FIFO
      repeat (20) @(negedge clk);
      chk("idle_cs_n", 32'(cs_n), 1);
      chk("idle_sclk", 32'(sclk), 0);
      chk("idle_mosi", 32'(mosi), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_strobes", 32'(strobe_cnt), 0);
      chk("idle_words", 32'(words_sent), 0);

      // Single word
      fifo_write(16'hA5C3);
      wait_drain(500);
      chk("single_words", 32'(words_sent), 1);
      chk("single_strobes", 32'(strobe_cnt), 1);
      chk("single_fault", 32'(fifo_fault), 0);

      // Back-to-back words
      fifo_write(16'h0001);
      wait_full_low(100);
      fifo_write(16'h8000);
      wait_drain(1000);
      chk("b2b_words", 32'(words_sent), 3);
      chk("b2b_strobes", 32'(strobe_cnt), 3);
      chk("b2b_fault", 32'(fifo_fault), 0);

      // Reset in the middle of a frame
      fifo_write(16'hFFFF);
      wait_bits(7, 500);
      rst     = 1'b1;
      discard = 1'b1;
      dropped = exp_q.pop_front();
      @(negedge clk);
      chk("midrst_cs_n", 32'(cs_n), 1);
      chk("midrst_sclk", 32'(sclk), 0);
      chk("midrst_mosi", 32'(mosi), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_words", 32'(words_sent), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_strobes", 32'(strobe_cnt), 4);
      chk("midrst_idle_busy", 32'(busy), 0);

      // Write coincident with the pop strobe
      fifo_write(16'h1234);
      wait_strobe(100);
      chk("pop_busy", 32'(busy), 1);
      fifo_write(16'h5678);
      chk("coinc_full", 32'(fifo_full), 1);
      wait_drain(1000);
      chk("coinc_words", 32'(words_sent), 2);
      chk("coinc_strobes", 32'(strobe_cnt), 6);
      chk("coinc_fault", 32'(fifo_fault), 0);

      // Counter wrap
      force dut.words_q = 16'hFFFF;
      @(negedge clk);
      release dut.words_q;
      @(negedge clk);
      fifo_write(16'hBEEF);
      wait_drain(500);
      chk("wrap_words", 32'(words_sent), 0);
      chk("wrap_busy", 32'(busy), 0);
      chk("wrap_fault", 32'(fifo_fault), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
